cache_l1_nway: RTL and testbench

Parametrised N-way set-associative L1 cache with true-LRU replacement, write-through and no-write-allocate. It sits between the CPU-side request port and the next memory level (L2), with a valid/ready request handshake and a req/ack memory handshake. Read misses stall the CPU until the fill completes. Each line holds one word.

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_l1_nway_lru.sv | 41 ++++
 rtl/cache_l1_nway.sv | 178 +++++++++++++++++
 tb/tb_cache_l1_nway.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way L1 cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cache_l1_nway_lru.sv
// True-LRU age tracking per set; victim is the way whose age is WAYS-1.
module lru_nway
    import cache_pkg::*;
#(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned SETS  = 2,
    parameter int unsigned IDX_W = clog2(SETS),
    parameter int unsigned AGE_W = clog2(WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] set,
    input  logic [AGE_W-1:0] way,
    input  logic             touch,
    output logic [AGE_W-1:0] victim_c
);

    logic [AGE_W-1:0] age [SETS][WAYS];

    // Touched way becomes youngest; ways younger than it age by one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < int'(SETS); s++)
                for (int w = 0; w < int'(WAYS); w++)
                    age[s][w] <= AGE_W'(w);
        end else if (touch) begin
            for (int w = 0; w < int'(WAYS); w++)
                if (age[set][w] < age[set][way])
                    age[set][w] <= age[set][w] + AGE_W'(1);
            age[set][way] <= '0;
        end
    end

    always_comb begin
        victim_c = '0;
        for (int w = 0; w < int'(WAYS); w++)
            if (age[set][w] == AGE_W'(WAYS - 1))
                victim_c = AGE_W'(w);
    end

endmodule

// File: rtl/cache_l1_nway.sv
// N-way set-associative L1 cache, write-through, no-write-allocate, one word per line.
module cache_l1_nway
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic              hit,
    output logic [DATA_W-1:0] q,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned IDX_W = clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;
    localparam int unsigned AGE_W = clog2(WAYS);

    state_t            state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_hit;

    logic [WAYS-1:0]   valid    [SETS];
    logic [TAG_W-1:0]  tag_arr  [SETS][WAYS];
    logic [DATA_W-1:0] data_arr [SETS][WAYS];

    logic [IDX_W-1:0]  idx_c;
    logic [TAG_W-1:0]  tag_c;
    logic              hit_c;
    logic [AGE_W-1:0]  hit_way_c;
    logic [AGE_W-1:0]  fill_way_c;
    logic [AGE_W-1:0]  lru_victim_c;
    logic [AGE_W-1:0]  touch_way_c;
    logic              fill_c;
    logic              wr_hit_c;
    logic              touch_c;

    assign idx_c = r_addr[IDX_W-1:0];
    assign tag_c = r_addr[ADDR_W-1:IDX_W];

    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = 0; w < int'(WAYS); w++)
            if (valid[idx_c][w] && (tag_arr[idx_c][w] == tag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = AGE_W'(w);
            end
    end

    // Prefer the lowest-index invalid way before evicting the LRU way.
    always_comb begin
        fill_way_c = lru_victim_c;
        for (int w = int'(WAYS) - 1; w >= 0; w--)
            if (!valid[idx_c][w])
                fill_way_c = AGE_W'(w);
    end

    assign fill_c      = (state == MEM_RD) && mem_ack;
    assign wr_hit_c    = (state == LOOKUP) && r_we && hit_c;
    assign touch_c     = ((state == LOOKUP) && hit_c) || fill_c;
    assign touch_way_c = fill_c ? fill_way_c : hit_way_c;

    lru_nway #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk      (clk),
        .reset    (reset),
        .set      (idx_c),
        .way      (touch_way_c),
        .touch    (touch_c),
        .victim_c (lru_victim_c)
    );

    // Tag and data storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (fill_c) begin
            tag_arr[idx_c][fill_way_c]  <= tag_c;
            data_arr[idx_c][fill_way_c] <= mem_rdata;
        end else if (wr_hit_c) begin
            data_arr[idx_c][hit_way_c]  <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cpu_ready <= 1'b1;
            cpu_done  <= 1'b0;
            hit       <= 1'b0;
            q         <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_hit     <= 1'b0;
            for (int s = 0; s < int'(SETS); s++)
                valid[s] <= '0;
        end else begin
            cpu_done <= 1'b0;
            if (fill_c)
                valid[idx_c][fill_way_c] <= 1'b1;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        r_we      <= cpu_we;
                        r_addr    <= cpu_addr;
                        r_wdata   <= cpu_wdata;
                        cpu_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_hit <= hit_c;
                    if (r_we) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= r_addr;
                        mem_wdata <= r_wdata;
                        state     <= MEM_WR;
                    end else if (hit_c) begin
                        q         <= data_arr[idx_c][hit_way_c];
                        hit       <= 1'b1;
                        cpu_done  <= 1'b1;
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= r_addr;
                        state     <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        q         <= mem_rdata;
                        hit       <= 1'b0;
                        cpu_done  <= 1'b1;
                        mem_req   <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                MEM_WR: begin
                    if (mem_ack) begin
                        q         <= r_wdata;
                        hit       <= r_hit;
                        cpu_done  <= 1'b1;
                        mem_req   <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_l1_nway.sv
// Directed bench: a 2-way/2-set and a 4-way/4-set cache share stimulus behind a select.
module tb_cache_l1_nway;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        cpu_req, cpu_we;
    logic [6:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    logic        cpu_ready0, cpu_done0, hit0, mem_req0, mem_we0;
    logic [15:0] q0, mem_wdata0;
    logic [6:0]  mem_addr0;
    logic        cpu_ready1, cpu_done1, hit1, mem_req1, mem_we1;
    logic [15:0] q1, mem_wdata1;
    logic [6:0]  mem_addr1;

    logic        cpu_ready_m, cpu_done_m, hit_m, mem_req_m, mem_we_m;
    logic [15:0] q_m, mem_wdata_m;
    logic [6:0]  mem_addr_m;

    always #5 clk = ~clk;

    cache_l1_nway #(.ADDR_W(7), .DATA_W(16), .WAYS(2), .SETS(2)) dut0 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req & ~sel), .cpu_ready(cpu_ready0),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done0),
        .hit(hit0), .q(q0), .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_ack(mem_ack & ~sel), .mem_rdata(mem_rdata));

    cache_l1_nway #(.ADDR_W(7), .DATA_W(16), .WAYS(4), .SETS(4)) dut1 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req & sel), .cpu_ready(cpu_ready1),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done1),
        .hit(hit1), .q(q1), .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_ack(mem_ack & sel), .mem_rdata(mem_rdata));

    assign cpu_ready_m = sel ? cpu_ready1 : cpu_ready0;
    assign cpu_done_m  = sel ? cpu_done1  : cpu_done0;
    assign hit_m       = sel ? hit1       : hit0;
    assign q_m         = sel ? q1         : q0;
    assign mem_req_m   = sel ? mem_req1   : mem_req0;
    assign mem_we_m    = sel ? mem_we1    : mem_we0;
    assign mem_addr_m  = sel ? mem_addr1  : mem_addr0;
    assign mem_wdata_m = sel ? mem_wdata1 : mem_wdata0;

    int          errors = 0;
    int          checks = 0;
    int          ack_delay = 3;
    int          wait_cnt = 0;
    int          mem_cnt = 0;
    logic [6:0]  last_addr;
    logic        last_we;
    logic [15:0] last_wdata;
    logic [15:0] l2 [128];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // L2 model: acks after ack_delay extra cycles, write-through updates its store.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req_m && !reset) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack    = 1'b1;
                    mem_rdata  = l2[mem_addr_m];
                    last_addr  = mem_addr_m;
                    last_we    = mem_we_m;
                    last_wdata = mem_wdata_m;
                    if (mem_we_m) l2[mem_addr_m] = mem_wdata_m;
                    mem_cnt++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_req(input logic we, input logic [6:0] addr, input logic [15:0] wd,
                          output logic h, output logic [15:0] rq, output int cyc, output int mreqs);
        int   m0;
        logic done;
        @(negedge clk);
        m0        = mem_cnt;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        cyc     = 1;
        done    = 1'b0;
        while (!done && cyc < 60) begin
            if (cpu_done_m) done = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", 32'(done), 32'd1);
        h     = hit_m;
        rq    = q_m;
        mreqs = mem_cnt - m0;
        @(negedge clk);
        check("done_pulse", 32'(cpu_done_m), 32'd0);
    endtask

    task automatic req_chk(input string tag, input logic we, input logic [6:0] addr,
                           input logic [15:0] wd, input logic exp_hit, input logic [15:0] exp_q,
                           input int exp_mem);
        logic        h;
        logic [15:0] rq;
        int          cyc, mreqs;
        do_req(we, addr, wd, h, rq, cyc, mreqs);
        check({tag, "_hit"}, 32'(h), 32'(exp_hit));
        check({tag, "_q"}, 32'(rq), 32'(exp_q));
        check({tag, "_mem"}, 32'(mreqs), 32'(exp_mem));
    endtask

    logic        h;
    logic [15:0] rq;
    int          cyc, mreqs;

    initial begin
        for (int i = 0; i < 128; i++) l2[i] = 16'hA000 + 16'(i);
        l2[4]     = 16'hBEEF;
        sel       = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_ready", 32'(cpu_ready_m), 32'd1);
        check("rst_done", 32'(cpu_done_m), 32'd0);
        check("rst_hit", 32'(hit_m), 32'd0);
        check("rst_q", 32'(q_m), 32'd0);
        check("rst_mem_req", 32'(mem_req_m), 32'd0);
        check("rst_mem_we", 32'(mem_we_m), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_m), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata_m), 32'd0);

        // Miss fill, then hit with two-cycle latency.
        ack_delay = 3;
        req_chk("t1_miss", 1'b0, 7'h04, 16'h0, 1'b0, 16'hBEEF, 1);
        do_req(1'b0, 7'h04, 16'h0, h, rq, cyc, mreqs);
        check("t1_hit", 32'(h), 32'd1);
        check("t1_q", 32'(rq), 32'hBEEF);
        check("t1_lat", 32'(cyc), 32'd2);
        check("t1_mem", 32'(mreqs), 32'd0);

        // Write hit goes through to L2 and updates the line.
        req_chk("t2_wr", 1'b1, 7'h04, 16'h1234, 1'b1, 16'h1234, 1);
        check("t2_waddr", 32'(last_addr), 32'h04);
        check("t2_wwe", 32'(last_we), 32'd1);
        check("t2_wdata", 32'(last_wdata), 32'h1234);
        req_chk("t2_rd", 1'b0, 7'h04, 16'h0, 1'b1, 16'h1234, 0);

        // LRU in set 0.
        ack_delay = 1;
        req_chk("t3_r00", 1'b0, 7'h00, 16'h0, 1'b0, 16'hA000, 1);
        req_chk("t3_r02", 1'b0, 7'h02, 16'h0, 1'b0, 16'hA002, 1);
        req_chk("t3_r00b", 1'b0, 7'h00, 16'h0, 1'b1, 16'hA000, 0);
        req_chk("t3_r04", 1'b0, 7'h04, 16'h0, 1'b0, 16'h1234, 1);
        req_chk("t3_r00c", 1'b0, 7'h00, 16'h0, 1'b1, 16'hA000, 0);
        req_chk("t3_r02b", 1'b0, 7'h02, 16'h0, 1'b0, 16'hA002, 1);

        // Write miss does not allocate; re-read also exercises a same-cycle ack.
        req_chk("t4_wr", 1'b1, 7'h06, 16'hAAAA, 1'b0, 16'hAAAA, 1);
        check("t4_wwe", 32'(last_we), 32'd1);
        ack_delay = 0;
        do_req(1'b0, 7'h06, 16'h0, h, rq, cyc, mreqs);
        check("t4_rd_hit", 32'(h), 32'd0);
        check("t4_rd_q", 32'(rq), 32'hAAAA);
        check("t4_rd_mem", 32'(mreqs), 32'd1);
        check("t4_rd_lat", 32'(cyc), 32'd3);

        // Reset during an outstanding fill.
        ack_delay = 10;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 7'h01;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("t5_req_up", 32'(mem_req_m), 32'd1);
        #1 reset = 1'b1;
        #1 check("t5_req_drop", 32'(mem_req_m), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_ready", 32'(cpu_ready_m), 32'd1);
        check("t5_no_done", 32'(cpu_done_m), 32'd0);
        ack_delay = 1;
        req_chk("t5_r00", 1'b0, 7'h00, 16'h0, 1'b0, 16'hA000, 1);

        // 4-way, 4-set: five tags into set 1.
        sel = 1'b1;
        @(negedge clk);
        check("t6_ready", 32'(cpu_ready_m), 32'd1);
        req_chk("t6_r01", 1'b0, 7'h01, 16'h0, 1'b0, 16'hA001, 1);
        req_chk("t6_r05", 1'b0, 7'h05, 16'h0, 1'b0, 16'hA005, 1);
        req_chk("t6_r09", 1'b0, 7'h09, 16'h0, 1'b0, 16'hA009, 1);
        req_chk("t6_r0d", 1'b0, 7'h0D, 16'h0, 1'b0, 16'hA00D, 1);
        req_chk("t6_r11", 1'b0, 7'h11, 16'h0, 1'b0, 16'hA011, 1);
        req_chk("t6_r05b", 1'b0, 7'h05, 16'h0, 1'b1, 16'hA005, 0);
        req_chk("t6_r01b", 1'b0, 7'h01, 16'h0, 1'b0, 16'hA001, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
